// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES joypad reader and related pad logic.
// Covers the scan FSM states, the button bit order and the control-byte bit map.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } pad_state_e;

    // Bit positions of each button in the captured byte (first bit shifted = A)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int CTRL_POLL = 0;
    localparam int CTRL_AUTO = 1;

    localparam int NUM_BUTTONS = 8;

    // Counter width for a count of n states; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nes_sync2.sv
// Generic two-flop synchronizer for pad and expansion-port inputs.
// Resets to zero asynchronously so the first sampled value is deterministic.
module nes_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// NES joypad reader: drives latch/clock, deserializes the 8 active-low buttons
// and presents them as a registered active-high byte with a valid strobe.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int DIV_CYCLES  = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ctrl_in,
    input  logic       pad_data_n,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PH_W   = cnt_width(2 * DIV_CYCLES);
    localparam int POLL_W = cnt_width(POLL_CYCLES);

    localparam logic [PH_W-1:0]   PH_LATCH_LAST = PH_W'(2 * DIV_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_HALF_LAST  = PH_W'(DIV_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST     = POLL_W'(POLL_CYCLES - 1);

    pad_state_e              state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [POLL_W-1:0]       poll_q, poll_d;
    logic [2:0]              bit_q, bit_d;
    logic [NUM_BUTTONS-1:0]  sreg_q, sreg_d;
    logic [NUM_BUTTONS-1:0]  buttons_q, buttons_d;
    logic                    poll_req_q;
    logic                    pad_latch_q, pad_latch_d;
    logic                    pad_clk_q, pad_clk_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;

    logic                    sync_data;
    logic                    start;
    logic                    auto_fire;
    logic [5:0]              unused_ctrl;

    assign unused_ctrl = ctrl_in[7:2];

    nes_sync2 #(.WIDTH(1)) u_data_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_data_n),
        .q       (sync_data)
    );

    // Edge on the poll bit; only honoured from IDLE, so requests during a scan are lost
    assign start     = ctrl_in[CTRL_POLL] & ~poll_req_q;
    assign auto_fire = ctrl_in[CTRL_AUTO] & (poll_q == POLL_LAST);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        poll_d    = '0;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        buttons_d = buttons_q;

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (start || auto_fire) begin
                    state_d = LATCH;
                end else if (ctrl_in[CTRL_AUTO]) begin
                    poll_d = poll_q + 1'b1;
                end
            end
            LATCH: begin
                if (phase_q == PH_LATCH_LAST) begin
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = SHIFT_LO;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_q == PH_HALF_LAST) begin
                    phase_d       = '0;
                    sreg_d[bit_q] = ~sync_data;
                    state_d       = SHIFT_HI;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (phase_q == PH_HALF_LAST) begin
                    phase_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                buttons_d = sreg_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin outputs decode the next state so they are flop outputs aligned with state_q
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != SHIFT_LO);
        busy_d      = (state_d == LATCH) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
        valid_d     = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            poll_q      <= '0;
            bit_q       <= '0;
            sreg_q      <= '0;
            buttons_q   <= '0;
            poll_req_q  <= 1'b0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            poll_q      <= poll_d;
            bit_q       <= bit_d;
            sreg_q      <= sreg_d;
            buttons_q   <= buttons_d;
            poll_req_q  <= ctrl_in[CTRL_POLL];
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a shift-register joypad model.
module tb_nes_pad_reader;

    localparam int DIV  = 4;
    localparam int POLL = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] ctrl_in = 8'h00;
    logic       pad_data_n;
    logic       pad_latch, pad_clk, valid, busy;
    logic [7:0] buttons;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nes_pad_reader #(.DIV_CYCLES(DIV), .POLL_CYCLES(POLL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_in    (ctrl_in),
        .pad_data_n (pad_data_n),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .buttons    (buttons),
        .valid      (valid),
        .busy       (busy)
    );

    // Joypad model: latch loads the pattern, each pad_clk rise shifts the next bit out
    logic [7:0] pat_a = 8'h00, pat_b = 8'h00, pad_sr = 8'h00;
    logic       alt_en = 1'b0, manual = 1'b0, man_data = 1'b1;
    int         alt_base = 0, scan_no = 0;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            pad_sr = (alt_en && (((scan_no - alt_base) % 2) == 1)) ? pat_b : pat_a;
            scan_no++;
        end else begin
            pad_sr = {1'b0, pad_sr[7:1]};
        end
    end

    assign pad_data_n = manual ? man_data : ~pad_sr[0];

    // Activity monitor, sampled on the falling clock edge
    int   cyc = 0, latch_rises = 0, latch_rise_cyc = 0, latch_len = 0, latch_run = 0;
    int   lo_pulses = 0, bad_lo = 0, bad_hi = 0, lo_run = 0, hi_run = 0;
    int   valid_cnt = 0, valid_cyc = 0, btn_glitch = 0;
    bit   hi_chk = 1'b0;
    logic latch_prev = 1'b0, clk_prev = 1'b1;
    logic [7:0] btn_prev = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            latch_prev = 1'b0;
            clk_prev   = 1'b1;
            hi_chk     = 1'b0;
            lo_run     = 0;
            latch_run  = 0;
            btn_prev   = buttons;
        end else begin
            if (pad_latch) begin
                latch_run++;
                hi_chk = 1'b0;
                if (!latch_prev) begin
                    latch_rises++;
                    latch_rise_cyc = cyc;
                end
            end else if (latch_prev) begin
                latch_len = latch_run;
                latch_run = 0;
            end
            if (!pad_clk) begin
                if (clk_prev) begin
                    if (hi_chk && hi_run != DIV) bad_hi++;
                    lo_run = 0;
                end
                lo_run++;
            end else begin
                if (!clk_prev) begin
                    lo_pulses++;
                    if (lo_run != DIV) bad_lo++;
                    hi_run = 0;
                    hi_chk = 1'b1;
                end
                hi_run++;
            end
            if (valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                hi_chk = 1'b0;
            end
            if (buttons !== btn_prev && !valid) btn_glitch++;
            btn_prev   = buttons;
            latch_prev = pad_latch;
            clk_prev   = pad_clk;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int target, input int bound, output bit ok);
        int n = 0;
        while (valid_cnt < target && n < bound) begin
            tick();
            n++;
        end
        ok = (valid_cnt >= target);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (pad_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", pad_latch); end
        checks++; if (pad_clk !== 1'b1) begin errors++; $display("FAIL reset_padclk: got %b want 1", pad_clk); end
        checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL reset_buttons: got %h want 00", buttons); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_poll();
        int vc, lr, lp, bl, bh, c0;
        bit ok;
        pat_a = 8'hA5; alt_en = 1'b0; manual = 1'b0;
        vc = valid_cnt; lr = latch_rises; lp = lo_pulses; bl = bad_lo; bh = bad_hi;
        ctrl_in = 8'h01;
        c0 = cyc;
        wait_valid(vc + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d valids want %0d", valid_cnt - vc, 1); end
        checks++; if (latch_rise_cyc != c0 + 1) begin errors++; $display("FAIL single_latch_latency: got %0d want %0d", latch_rise_cyc - c0, 1); end
        checks++; if (latch_len != 2 * DIV) begin errors++; $display("FAIL single_latch_len: got %0d want %0d", latch_len, 2 * DIV); end
        checks++; if (lo_pulses - lp != 8) begin errors++; $display("FAIL single_clk_pulses: got %0d want 8", lo_pulses - lp); end
        checks++; if (bad_lo != bl) begin errors++; $display("FAIL single_clk_low_len: got %0d bad want 0", bad_lo - bl); end
        checks++; if (bad_hi != bh) begin errors++; $display("FAIL single_clk_high_len: got %0d bad want 0", bad_hi - bh); end
        checks++; if (valid_cyc - latch_rise_cyc != 18 * DIV + 1) begin errors++; $display("FAIL single_valid_latency: got %0d want %0d", valid_cyc - latch_rise_cyc, 18 * DIV + 1); end
        checks++; if (buttons !== 8'hA5) begin errors++; $display("FAIL single_buttons: got %h want a5", buttons); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b want 0", valid); end
        checks++; if (latch_rises - lr != 1) begin errors++; $display("FAIL single_latch_count: got %0d want 1", latch_rises - lr); end
        ctrl_in = 8'h00;
        tick();
    endtask

    task automatic test_back_to_back();
        int vc, lr, n;
        bit ok;
        pat_a = 8'hA5;
        vc = valid_cnt; lr = latch_rises;
        ctrl_in = 8'h01;
        n = 0;
        while (pad_clk !== 1'b0 && n < 50) begin tick(); n++; end
        checks++; if (pad_clk !== 1'b0) begin errors++; $display("FAIL retrig_shift_lo: got pad_clk %b want 0", pad_clk); end
        ctrl_in = 8'h00; tick();
        ctrl_in = 8'h01; tick();
        ctrl_in = 8'h00; tick();
        ctrl_in = 8'h01; tick();
        wait_valid(vc + 1, 200, ok);
        checks++; if (buttons !== 8'hA5) begin errors++; $display("FAIL retrig_buttons: got %h want a5", buttons); end
        repeat (150) tick();
        checks++; if (valid_cnt - vc != 1) begin errors++; $display("FAIL retrig_valid_count: got %0d want 1", valid_cnt - vc); end
        checks++; if (latch_rises - lr != 1) begin errors++; $display("FAIL retrig_scan_count: got %0d want 1", latch_rises - lr); end
        ctrl_in = 8'h00;
        tick();
    endtask

    task automatic test_auto_poll();
        int vc, lr, vcyc, n;
        bit ok;
        logic [7:0] exp;
        pat_a = 8'h01; pat_b = 8'h80; alt_base = scan_no; alt_en = 1'b1;
        vc = valid_cnt; lr = latch_rises;
        ctrl_in = 8'h02;
        wait_valid(vc + 1, 300, ok);
        checks++; if (!ok || buttons !== 8'h01) begin errors++; $display("FAIL auto_first: got %h (ok=%0b) want 01", buttons, ok); end
        for (int k = 2; k <= 3; k++) begin
            vcyc = valid_cyc;
            exp = (k % 2 == 0) ? 8'h80 : 8'h01;
            wait_valid(vc + k, 300, ok);
            checks++; if (!ok || latch_rise_cyc - vcyc != POLL) begin errors++; $display("FAIL auto_interval_%0d: got %0d want %0d", k, latch_rise_cyc - vcyc, POLL); end
            checks++; if (buttons !== exp) begin errors++; $display("FAIL auto_buttons_%0d: got %h want %h", k, buttons, exp); end
        end
        vcyc = valid_cyc;
        n = 0;
        while (latch_rises - lr < 4 && n < 300) begin tick(); n++; end
        repeat (20) tick();
        ctrl_in = 8'h00;
        wait_valid(vc + 4, 300, ok);
        checks++; if (!ok || buttons !== 8'h80) begin errors++; $display("FAIL auto_stop_scan: got %h (ok=%0b) want 80", buttons, ok); end
        checks++; if (latch_rise_cyc - vcyc != POLL) begin errors++; $display("FAIL auto_interval_4: got %0d want %0d", latch_rise_cyc - vcyc, POLL); end
        repeat (300) tick();
        checks++; if (latch_rises - lr != 4) begin errors++; $display("FAIL auto_stopped: got %0d scans want 4", latch_rises - lr); end
        alt_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int vc, falls, n;
        bit ok;
        logic prev;
        pat_a = 8'hFF;
        ctrl_in = 8'h01;
        falls = 0; n = 0; prev = pad_clk;
        while (falls < 4 && n < 300) begin
            tick();
            if (prev && !pad_clk) falls++;
            prev = pad_clk;
            n++;
        end
        checks++; if (falls != 4) begin errors++; $display("FAIL midrst_reach_bit3: got %0d falls want 4", falls); end
        reset_n = 1'b0;
        #1;
        checks++; if (pad_latch !== 1'b0 || pad_clk !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL midrst_pins: got latch=%b clk=%b busy=%b valid=%b want 0 1 0 0", pad_latch, pad_clk, busy, valid); end
        checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL midrst_buttons: got %h want 00", buttons); end
        ctrl_in = 8'h00;
        tick(); tick();
        reset_n = 1'b1;
        vc = valid_cnt;
        repeat (100) tick();
        checks++; if (valid_cnt != vc || buttons !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got valids=%0d buttons=%h busy=%b want 0 00 0", valid_cnt - vc, buttons, busy); end
        ctrl_in = 8'h01;
        wait_valid(vc + 1, 200, ok);
        checks++; if (!ok || buttons !== 8'hFF) begin errors++; $display("FAIL midrst_fresh_poll: got %h (ok=%0b) want ff", buttons, ok); end
        ctrl_in = 8'h00;
        tick();
    endtask

    task automatic test_async_data();
        int vc, n;
        bit ok;
        manual = 1'b1; man_data = 1'b0;
        vc = valid_cnt;
        ctrl_in = 8'h01;
        n = 0;
        while (pad_clk !== 1'b0 && n < 50) begin tick(); n++; end
        repeat (3) tick();
        man_data = 1'b1;
        wait_valid(vc + 1, 200, ok);
        checks++; if (!ok || buttons !== 8'h01) begin errors++; $display("FAIL async_old_value: got %h (ok=%0b) want 01", buttons, ok); end
        checks++; if ((^buttons) === 1'bx) begin errors++; $display("FAIL async_no_x: got %b want no X", buttons); end
        manual = 1'b0;
        ctrl_in = 8'h00;
        tick();
    endtask

    task automatic test_buttons_stable();
        checks++; if (btn_glitch != 0) begin errors++; $display("FAIL buttons_stable: got %0d changes outside valid want 0", btn_glitch); end
    endtask

    initial begin
        test_reset();
        test_single_poll();
        test_back_to_back();
        test_auto_poll();
        test_reset_mid_scan();
        test_async_data();
        test_buttons_stable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Downstream consumer of the 8-bit PIO control byte in nesTop. The CPU writes the byte; this block receives it on ctrl_in.
- On command, the block drives the NES joypad latch and clock lines. It deserializes the 8 active-low button bits and presents them as a registered active-high byte with a one-cycle valid strobe.
- Supports single-shot polling and periodic auto-polling.

Parameters:
- DIV_CYCLES, 300: clk cycles per pad_clk half-period. At 50 MHz this gives 6 us. Must be >= 4.
- POLL_CYCLES, 833333: idle clk cycles between auto-polls, measured from valid to the next latch (~60 Hz at 50 MHz). Must be >= 1.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- ctrl_in, input, 8: control byte from the PIO out_port. Bit 0 = poll request (rising edge). Bit 1 = auto-poll enable. Bits 7:2 are ignored.
- pad_data_n, input, 1: serial data from the joypad, active-low, asynchronous to clk.
- pad_latch, output, 1: joypad latch, active-high.
- pad_clk, output, 1: joypad clock, idles high.
- buttons, output, 8: last captured buttons, active-high. Bit order, bit0..bit7: A, B, Select, Start, Up, Down, Left, Right.
- valid, output, 1: one-cycle pulse when buttons updates.
- busy, output, 1: high from LATCH through SHIFT_HI.

Behaviour:
- Reset values: pad_latch=0, pad_clk=1, buttons=8'h00, valid=0, busy=0, state=IDLE. All counters and synchronizer flops are 0.
- Reset is asynchronous and may occur mid-scan. The block returns to IDLE immediately and the partial shift register is discarded.
- Synchronization: pad_data_n passes through a 2-flop synchronizer. The synchronized value is sampled, never the raw pin.
- Start detection: ctrl_in[0] is registered each cycle. start = ctrl_in[0] & ~ctrl_q0, accepted only in IDLE. Start edges seen outside IDLE are dropped, not queued.
- State IDLE:
  - pad_latch=0, pad_clk=1.
  - Go to LATCH on start.
  - Or go to LATCH when ctrl_in[1]=1 and the poll counter reaches POLL_CYCLES-1.
  - The poll counter runs only in IDLE while ctrl_in[1]=1. It clears on leaving IDLE and whenever ctrl_in[1]=0.
- State LATCH:
  - pad_latch=1 for 2*DIV_CYCLES cycles.
  - Bit index i=0. Then go to SHIFT_LO.
- State SHIFT_LO:
  - pad_latch=0, pad_clk=0 for DIV_CYCLES cycles.
  - On the last cycle, sreg[i] <= ~sync_data. Then go to SHIFT_HI.
- State SHIFT_HI:
  - pad_clk=1 for DIV_CYCLES cycles. The pad shifts its next bit on this rising edge.
  - At the end: if i==7, go to DONE; otherwise i<=i+1 and go to SHIFT_LO.
- State DONE (1 cycle):
  - buttons <= sreg, valid=1, busy=0 on the following cycle.
  - Go to IDLE.
- Latency: pad_latch rises on the cycle after start is detected. valid is asserted 18*DIV_CYCLES+1 cycles after pad_latch rises.
- Output stability:
  - buttons changes only in DONE and holds between scans.
  - Exactly 8 pad_clk low pulses per scan.
  - pad_latch and pad_clk are registered, so they are glitch-free.
- Simultaneous events: if start and the auto-poll expiry coincide in IDLE, exactly one scan runs.
- ctrl_in[1] deasserted mid-scan: the current scan completes and no further auto-poll follows.
- Widths:
  - Phase counter is $clog2(2*DIV_CYCLES) bits.
  - Poll counter is $clog2(POLL_CYCLES) bits, minimum 1.
  - Bit index is 3 bits.
  - All counters wrap only by explicit clear, never by overflow.

Decomposition:
- Package nes_pad_pkg holds:
  - the state enum (IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE);
  - the button bit-index constants (BTN_A=0 .. BTN_RIGHT=7);
  - the ctrl_in bit constants (CTRL_POLL=0, CTRL_AUTO=1).
- One sub-module, nes_sync2: a generic 2-flop synchronizer with async active-low reset. It is reused later for other pad and expansion-port inputs.

Test Plan (DIV_CYCLES=4, POLL_CYCLES=100; the pad model shifts out the pattern on pad_clk rising edges with active-low data):
- Reset check: hold reset_n=0 -> pad_latch=0, pad_clk=1, buttons=00, valid=0, busy=0.
- Single poll, pattern 8'hA5:
  - Stimulus: raise ctrl_in[0] with the pad model loaded with 8'hA5.
  - pad_latch is high for exactly 8 cycles.
  - pad_clk shows 8 low pulses, each 4 cycles low and 4 cycles high.
  - valid pulses once, 73 cycles after the latch rise, with buttons=8'hA5.
- Retrigger while busy: toggle ctrl_in[0] 0->1->0->1 during SHIFT_LO -> no extra scan; only one valid; buttons=8'hA5.
- Auto-poll:
  - Stimulus: set ctrl_in=8'h02 with the pad pattern alternating 8'h01 and 8'h80.
  - Each latch rise occurs 100 cycles after the prior valid.
  - buttons alternates 01, 80.
  - Clearing bit 1 mid-scan completes that scan and then stops polling.
- Reset mid-scan:
  - Stimulus: assert reset_n=0 at bit 3 of a scan with pattern FF.
  - Outputs return to reset values immediately and buttons stays 00.
  - A fresh poll afterwards yields FF.
- Asynchronous data: change pad_data_n 1 cycle before the end of SHIFT_LO -> the old value is captured (synchronizer delay). No X propagates to buttons.
